// File: rtl/branch_flag_resolver_pkg.sv
// Shared constants for the stage-4 branch flag resolver.
// Flag bit positions, condition codes and FSM state encoding.
package branch_flag_resolver_pkg;

   localparam int FL_CY = 3;
   localparam int FL_Z  = 2;
   localparam int FL_S  = 1;
   localparam int FL_P  = 0;

   localparam logic [2:0] CC_CY1 = 3'b000;
   localparam logic [2:0] CC_CY0 = 3'b001;
   localparam logic [2:0] CC_Z1  = 3'b010;
   localparam logic [2:0] CC_Z0  = 3'b011;
   localparam logic [2:0] CC_S1  = 3'b100;
   localparam logic [2:0] CC_S0  = 3'b101;
   localparam logic [2:0] CC_P1  = 3'b110;
   localparam logic [2:0] CC_P0  = 3'b111;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/branch_flag_resolver_flag_cond_eval.sv
// Combinational evaluation of the <fl> condition field
// against the current flag register {CY, Z, S, P}.
module flag_cond_eval
   import branch_flag_resolver_pkg::*;
(
   input  logic [2:0] fl,
   input  logic [3:0] flags,
   output logic       cond
);

   // Select one flag and the polarity it must match
   always_comb begin
      cond = 1'b0;
      unique case (fl)
         CC_CY1: cond =  flags[FL_CY];
         CC_CY0: cond = ~flags[FL_CY];
         CC_Z1:  cond =  flags[FL_Z];
         CC_Z0:  cond = ~flags[FL_Z];
         CC_S1:  cond =  flags[FL_S];
         CC_S0:  cond = ~flags[FL_S];
         CC_P1:  cond =  flags[FL_P];
         CC_P0:  cond = ~flags[FL_P];
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_flag_resolver.sv
// Stage-4 flag register, branch condition resolution and
// squash sequencing for a predict-not-taken pipeline.
module branch_flag_resolver
   import branch_flag_resolver_pkg::*;
#(
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [7:0]       opcode,
   input  logic             efl,
   input  logic             s_al,
   input  logic             lpc,
   input  logic [3:0]       alu_flags,
   output logic             take_branch,
   output logic             flush,
   output logic             cond_true,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] branch_count
);

   localparam int CW = $clog2(FLUSH_DEPTH + 1);

   logic [0:0]    state;
   logic [CW-1:0] fcnt;
   logic          hit;
   logic          unused_op;

   assign unused_op = ^opcode[7:3];

   flag_cond_eval u_eval (
      .fl    (opcode[2:0]),
      .flags (flags),
      .cond  (hit)
   );

   // Flag register, branch strobe, squash window and taken counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         fcnt         <= '0;
         flags        <= '0;
         take_branch  <= 1'b0;
         flush        <= 1'b0;
         cond_true    <= 1'b0;
         branch_count <= '0;
      end else if (!stall) begin
         unique case (state)
            ST_IDLE: begin
               if (s_al)
                  flags <= alu_flags;
               if (efl)
                  cond_true <= hit;
               if (efl && lpc && hit) begin
                  take_branch <= 1'b1;
                  flush       <= 1'b1;
                  fcnt        <= CW'(FLUSH_DEPTH - 1);
                  state       <= ST_FLUSH;
                  if (branch_count != '1)
                     branch_count <= branch_count + CNT_W'(1);
               end else begin
                  take_branch <= 1'b0;
                  flush       <= 1'b0;
               end
            end
            ST_FLUSH: begin
               take_branch <= 1'b0;
               if (fcnt == '0) begin
                  flush <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  fcnt <= fcnt - CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/branch_flag_resolver.md
Name: branch_flag_resolver

Overview:
- Stage-4 consumer of the stage-3 control codes EFL, S_AL and LPC, plus the stage-3 opcode.
- Holds the architectural flag register. Evaluates the <fl> condition of conditional jump/call/return opcodes (JCD, JCA, CCD, CCA, RTC).
- Issues a one-cycle PC-load strobe and a multi-cycle squash of stages 1-2 on a taken branch.
- The pipeline is predict-not-taken, so a not-taken branch costs no cycles.

Parameters:
- FLUSH_DEPTH, 2, cycles `flush` stays high after a taken branch (1..7).
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  downstream hold; freezes every register in this block
- opcode  in  8  stage-3 opcode; bits [2:0] are the <fl> field
- efl  in  1  enable flag evaluation (conditional-class opcode)
- s_al  in  1  ALU result valid; load flags from alu_flags
- lpc  in  1  load PC if the condition is true
- alu_flags  in  4  {CY, Z, S, P} from the ALU
- take_branch  out  1  registered one-cycle PC-load strobe
- flush  out  1  registered squash of stages 1-2
- cond_true  out  1  registered result of the last evaluation
- flags  out  4  current flag register {CY, Z, S, P}
- branch_count  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (async, immediate): flags=0, take_branch=0, flush=0, cond_true=0, branch_count=0, state=IDLE, flush counter=0.
- All inputs are sampled on the rising edge of clk. All outputs are registered, giving 1-cycle latency from input to response.
- stall=1 holds every register and output at its current value; no evaluation takes place.
- Condition encoding by fl:
  - 000 CY=1; 001 CY=0
  - 010 Z=1; 011 Z=0
  - 100 S=1; 101 S=0
  - 110 P=1; 111 P=0
- States:
  - IDLE: squashed inputs are not applicable; efl, s_al and lpc are acted on normally.
  - FLUSH: carries a down-counter of width ceil(log2(FLUSH_DEPTH+1)).
- IDLE, s_al=1: flags <= alu_flags.
- IDLE, efl=1: cond_true <= cond(opcode[2:0], flags).
  - The evaluation uses the pre-update flags, even if s_al is also 1 in the same cycle.
- IDLE, efl=1, lpc=1 and the condition is true:
  - take_branch <= 1 and flush <= 1; counter <= FLUSH_DEPTH-1; go to FLUSH.
  - branch_count increments and saturates at all-ones.
- IDLE, condition false or lpc=0: take_branch=0, flush=0; stay in IDLE.
- efl=0: cond_true holds its previous value.
- FLUSH:
  - take_branch <= 0 after its single cycle; flush stays at 1.
  - efl, s_al and lpc are ignored, because they belong to wrong-path instructions. Flags and count do not change.
  - When the counter reaches 0: flush <= 0, go to IDLE, and inputs in that same cycle are ignored.
  - Total flush high time is exactly FLUSH_DEPTH cycles.
- FLUSH_DEPTH=1: the block returns to IDLE on the cycle after take_branch.
- Back-to-back taken branches: the second one is squashed and has no effect.
- Reset during FLUSH: return to IDLE immediately; flush drops asynchronously.
- Stall during FLUSH: the counter freezes and flush stays high for the full length of the stall.

Decomposition:
- Shared package constants:
  - flag bit indices: FL_CY=3, FL_Z=2, FL_S=1, FL_P=0
  - the 3-bit condition codes
  - state encoding IDLE=0, FLUSH=1
- One sub-module, flag_cond_eval: combinational, takes (fl[2:0], flags[3:0]) and returns true.
- The state machine, flag register and counter stay in the top module.

Test Plan:
- Flag load and taken branch: rst pulse, s_al=1 with alu_flags=4'b0100, then opcode=8'b0010_1010 (JCA Z) with efl=1, lpc=1 -> flags=0100; next cycle take_branch=1 and flush=1; flush high exactly 2 cycles; branch_count=1.
- Not-taken branch: flags=0000, opcode 8'b0000_1000 (JCD CY) with efl=1, lpc=1 -> cond_true=0, take_branch=0, flush=0, count unchanged.
- Pre-update evaluation: flags=1000, same cycle s_al=1 with alu_flags=0000 and efl=1 with fl=000 -> branch taken (old CY used); flags=0000 afterwards.
- Squashed wrong path: during FLUSH apply s_al=1 with alu_flags=1111, then efl=1, lpc=1 -> flags unchanged, no second take_branch, count unchanged.
- Stall and reset: stall=1 mid-FLUSH for 3 cycles -> flush holds for 2+3 cycles total; separately, rst asserted mid-FLUSH -> all outputs 0 without waiting for a clock edge.
- Saturation: CNT_W=2, five taken branches spaced more than FLUSH_DEPTH apart -> branch_count stops at 3.
